// File: rtl/regfile_mp_pkg.sv
// regfile_mp_pkg: shared defaults, sequencer state encodings and the zero word
package regfile_mp_pkg;
  localparam int REG_NUM_LOG2 = 5;
  localparam int DATA_W_DEF = 32;
  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN = 1'b1;
  localparam logic [DATA_W_DEF-1:0] ZERO_WORD = '0;
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: pending-write busy bits with issue/writeback/flush priority and per-port busy lookup
module regfile_scoreboard
  import regfile_mp_pkg::*;
#(
  parameter int ADDR_W = REG_NUM_LOG2,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     run,
  input  logic [NUM_WR-1:0]        we,
  input  logic [NUM_WR*ADDR_W-1:0] waddr,
  input  logic [NUM_RD-1:0]        re,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  input  logic                     iss_vld,
  input  logic [ADDR_W-1:0]        iss_addr,
  input  logic                     flush,
  output logic [NUM_RD-1:0]        rbusy
);
  localparam int NREG = 2 ** ADDR_W;
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_n;
  logic [NUM_RD-1:0] hit;
  always_comb begin
    busy_n = busy;
    if (run) begin
      if (flush) busy_n = '0;
      for (int p = 0; p < NUM_WR; p++)
        if (we[p]) busy_n[waddr[p*ADDR_W +: ADDR_W]] = 1'b0;
      if (iss_vld) busy_n[iss_addr] = 1'b1;
    end
    busy_n[0] = 1'b0;
  end
  always_ff @(posedge clk) busy <= rst ? '0 : busy_n;
  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_RD; i++)
      for (int p = 0; p < NUM_WR; p++)
        if (we[p] && waddr[p*ADDR_W +: ADDR_W] == raddr[i*ADDR_W +: ADDR_W]) hit[i] = 1'b1;
  end
  // A same-cycle writeback resolves the hazard through the read bypass
  always_comb begin
    rbusy = '0;
    for (int i = 0; i < NUM_RD; i++)
      rbusy[i] = run && re[i] && raddr[i*ADDR_W +: ADDR_W] != '0
                 && busy[raddr[i*ADDR_W +: ADDR_W]] && !hit[i];
  end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with write-to-read bypass, hazard scoreboard and post-reset clear sweep
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = REG_NUM_LOG2,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_WR-1:0]        we,
  input  logic [NUM_WR*ADDR_W-1:0] waddr,
  input  logic [NUM_WR*DATA_W-1:0] wdata,
  input  logic [NUM_RD-1:0]        re,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic [NUM_RD-1:0]        rbusy,
  input  logic                     iss_vld,
  input  logic [ADDR_W-1:0]        iss_addr,
  input  logic                     flush,
  output logic                     ready
);
  localparam int NREG = 2 ** ADDR_W;
  logic [0:0] state;
  logic [ADDR_W-1:0] clr_ptr;
  logic [DATA_W-1:0] regs [NREG];
  logic run;
  assign run = state == ST_RUN && !rst;
  assign ready = run;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_INIT;
      clr_ptr <= ADDR_W'(1);
    end else if (state == ST_INIT) begin
      clr_ptr <= clr_ptr + ADDR_W'(1);
      if (clr_ptr == ADDR_W'(NREG - 1)) state <= ST_RUN;
    end
  end
  // Array has no reset so it can map to distributed RAM; register 0 is never written and never read
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == ST_INIT) regs[clr_ptr] <= DATA_W'(ZERO_WORD);
      else
        for (int p = 0; p < NUM_WR; p++)
          if (we[p] && waddr[p*ADDR_W +: ADDR_W] != '0)
            regs[waddr[p*ADDR_W +: ADDR_W]] <= wdata[p*DATA_W +: DATA_W];
    end
  end
  // Ascending port loop lets the highest-index matching writer win the bypass
  always_comb begin
    rdata = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      rdata[i*DATA_W +: DATA_W] = regs[raddr[i*ADDR_W +: ADDR_W]];
      for (int p = 0; p < NUM_WR; p++)
        if (we[p] && waddr[p*ADDR_W +: ADDR_W] == raddr[i*ADDR_W +: ADDR_W])
          rdata[i*DATA_W +: DATA_W] = wdata[p*DATA_W +: DATA_W];
      if (!(run && re[i] && raddr[i*ADDR_W +: ADDR_W] != '0))
        rdata[i*DATA_W +: DATA_W] = DATA_W'(ZERO_WORD);
    end
  end
  regfile_scoreboard #(.ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR)) u_sb (
    .clk(clk), .rst(rst), .run(run), .we(we), .waddr(waddr), .re(re), .raddr(raddr),
    .iss_vld(iss_vld), .iss_addr(iss_addr), .flush(flush), .rbusy(rbusy)
  );
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed self-checking bench for regfile_mp
module tb_regfile_mp;
  localparam int DW = 32;
  localparam int AW = 5;
  logic clk = 0;
  logic rst;
  logic [1:0] we;
  logic [2*AW-1:0] waddr;
  logic [2*DW-1:0] wdata;
  logic [1:0] re;
  logic [2*AW-1:0] raddr;
  logic [2*DW-1:0] rdata;
  logic [1:0] rbusy;
  logic iss_vld;
  logic [AW-1:0] iss_addr;
  logic flush;
  logic ready;
  int passed = 0;
  int checks = 0;
  regfile_mp dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .re(re), .raddr(raddr),
    .rdata(rdata), .rbusy(rbusy), .iss_vld(iss_vld), .iss_addr(iss_addr), .flush(flush), .ready(ready)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic idle;
    we = '0; waddr = '0; wdata = '0; re = '0; raddr = '0;
    iss_vld = 0; iss_addr = '0; flush = 0;
  endtask
  task automatic wr(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
    we[p] = 1'b1; waddr[p*AW +: AW] = a; wdata[p*DW +: DW] = d;
  endtask
  task automatic rd(input int p, input logic [AW-1:0] a);
    re[p] = 1'b1; raddr[p*AW +: AW] = a;
  endtask
  task automatic sweep_wait;
    int n = 0;
    while (!ready && n < 100) begin
      tick;
      n++;
      if (!ready) chk("init_rdata", {rbusy, rdata}, '0);
    end
    chk("sweep_len", n, 31);
  endtask
  initial begin
    idle;
    rst = 1;
    rd(0, 3); rd(1, 9);
    tick; tick;
    chk("rst_ready", ready, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_rbusy", rbusy, 0);
    rst = 0;
    sweep_wait;
    idle;
    for (int a = 1; a < 32; a++) begin
      wr(0, AW'(a), $urandom | 32'h1);
      tick;
    end
    idle;
    rd(0, 17);
    #1 chk("preload_nonzero", rdata[31:0] != 0, 1);
    rst = 1;
    tick;
    rst = 0;
    wr(0, 3, 32'h0000ABCD); wr(1, 3, 32'h0000ABCE);
    iss_vld = 1; iss_addr = 3; flush = 0;
    rd(0, 3); rd(1, 3);
    sweep_wait;
    idle;
    for (int a = 1; a < 32; a++) begin
      rd(0, AW'(a));
      #1 chk("swept_zero", rdata[31:0], 0);
    end
    rd(1, 3);
    #1 chk("init_write_lost", rdata[63:32], 0);
    chk("init_issue_lost", rbusy[1], 0);
    tick; idle;
    wr(0, 5, 32'h11111111); wr(1, 5, 32'h22222222);
    rd(0, 5); rd(1, 5);
    #1 chk("bypass_p0", rdata[31:0], 32'h22222222);
    chk("bypass_p1", rdata[63:32], 32'h22222222);
    tick; idle; rd(0, 5);
    #1 chk("dual_write_prio", rdata[31:0], 32'h22222222);
    tick; idle;
    wr(0, 0, 32'hDEADBEEF); iss_vld = 1; iss_addr = 0;
    rd(0, 0); rd(1, 0);
    #1 chk("zero_bypass", rdata, 0);
    chk("zero_busy_same", rbusy, 0);
    tick; idle; rd(0, 0);
    #1 chk("zero_read", rdata[31:0], 0);
    chk("zero_busy", rbusy, 0);
    tick; idle;
    iss_vld = 1; iss_addr = 7; rd(1, 7);
    #1 chk("issue_not_yet", rbusy[1], 0);
    tick; idle; rd(1, 7);
    #1 chk("issue_busy", rbusy[1], 1);
    chk("issue_old_data", rdata[63:32], 0);
    tick;
    chk("busy_holds", rbusy[1], 1);
    wr(0, 7, 32'h55);
    #1 chk("wb_rbusy", rbusy[1], 0);
    chk("wb_bypass", rdata[63:32], 32'h55);
    tick; idle; rd(1, 7);
    #1 chk("wb_cleared", rbusy[1], 0);
    chk("wb_data", rdata[63:32], 32'h55);
    tick; idle;
    iss_vld = 1; iss_addr = 9;
    tick; idle;
    iss_vld = 1; iss_addr = 3;
    tick; idle;
    rd(0, 9); rd(1, 3);
    #1 chk("pre_busy", rbusy, 2'b11);
    iss_vld = 1; iss_addr = 9; wr(0, 9, 32'h77); flush = 1;
    tick; idle; rd(0, 9); rd(1, 3);
    #1 chk("simul_busy", rbusy, 2'b01);
    chk("simul_data", rdata[31:0], 32'h77);
    flush = 1;
    tick; idle; rd(0, 9);
    #1 chk("flush_clear", rbusy[0], 0);
    wr(0, 4, 32'h99); iss_vld = 1; iss_addr = 4;
    tick; idle; rd(0, 4); rd(1, 4);
    #1 chk("pre_rst_busy", rbusy, 2'b11);
    chk("pre_rst_data", rdata[31:0], 32'h99);
    rst = 1;
    #1 chk("mid_rst_rbusy", rbusy, 0);
    chk("mid_rst_ready", ready, 0);
    chk("mid_rst_rdata", rdata, 0);
    tick;
    rst = 0;
    sweep_wait;
    #1 chk("post_rst_data", rdata[31:0], 0);
    chk("post_rst_busy", rbusy, 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
